// File: rtl/mod_bit_serializer.sv
// Byte-to-bit serializer feeding the BPSK/QPSK modulator: valid/ready byte input,
// programmable bit period, registered serial outputs. Optional macro: MOD_SER_PREAMBLE_EN.
module mod_bit_serializer #(
  parameter int                DATA_W        = 8,
  parameter int                DIV_W         = 8,
  parameter int                MSB_FIRST     = 1,
  parameter logic [DATA_W-1:0] PREAMBLE_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              data_out,
  output logic              mod_en,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  // Handshake: a byte transfers on a rising clk edge where s_valid && s_ready;
  // s_ready is registered and is high only in IDLE and in the final cycle of a byte.

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef MOD_SER_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PREAMBLE = 2'd2} state_t;
  logic [DATA_W-1:0] hold_q, hold_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t            state, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_adv;
  logic [DIV_W-1:0]  div_latch, latch_d, div_cnt, div_d;
  logic [CNT_W-1:0]  bit_cnt, bit_d;
  logic              strobe_d, accept;

  assign accept    = s_valid && s_ready;
  assign shift_adv = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0}
                                      : {1'b0, shift_q[DATA_W-1:1]};
  assign state_dbg = state;

  always_comb begin
    state_d  = state;
    shift_d  = shift_q;
    latch_d  = div_latch;
    div_d    = div_cnt;
    bit_d    = bit_cnt;
    strobe_d = 1'b0;
`ifdef MOD_SER_PREAMBLE_EN
    hold_d   = hold_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          latch_d  = baud_div;
          div_d    = baud_div;
          bit_d    = '0;
          strobe_d = 1'b1;
`ifdef MOD_SER_PREAMBLE_EN
          hold_d   = s_data;
          shift_d  = PREAMBLE_BYTE;
          state_d  = PREAMBLE;
`else
          shift_d  = s_data;
          state_d  = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_d = div_cnt - 1'b1;
        end else if (bit_cnt != LAST_BIT) begin
          shift_d  = shift_adv;
          bit_d    = bit_cnt + 1'b1;
          div_d    = div_latch;
          strobe_d = 1'b1;
        end else if (accept) begin
          // Back-to-back byte: reload on the final edge so mod_en never drops
          shift_d  = s_data;
          latch_d  = baud_div;
          div_d    = baud_div;
          bit_d    = '0;
          strobe_d = 1'b1;
        end else begin
          state_d = IDLE;
          shift_d = '0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
`ifdef MOD_SER_PREAMBLE_EN
      PREAMBLE: begin
        if (div_cnt != '0) begin
          div_d = div_cnt - 1'b1;
        end else if (bit_cnt != LAST_BIT) begin
          shift_d  = shift_adv;
          bit_d    = bit_cnt + 1'b1;
          div_d    = div_latch;
          strobe_d = 1'b1;
        end else begin
          shift_d  = hold_q;
          div_d    = div_latch;
          bit_d    = '0;
          strobe_d = 1'b1;
          state_d  = SHIFT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so every port comes straight off a flop
  logic data_d, mod_en_d, done_d, ready_d;
  always_comb begin
    mod_en_d = (state_d != IDLE);
    data_d   = mod_en_d && ((MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0]);
    done_d   = (state_d == SHIFT) && (bit_d == LAST_BIT) && (div_d == '0);
    ready_d  = (state_d == IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      div_latch  <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      s_ready    <= 1'b0;
      data_out   <= 1'b0;
      mod_en     <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef MOD_SER_PREAMBLE_EN
      hold_q     <= '0;
`endif
    end else begin
      state      <= state_d;
      shift_q    <= shift_d;
      div_latch  <= latch_d;
      div_cnt    <= div_d;
      bit_cnt    <= bit_d;
      s_ready    <= ready_d;
      data_out   <= data_d;
      mod_en     <= mod_en_d;
      bit_strobe <= strobe_d;
      busy       <= mod_en_d;
      frame_done <= done_d;
`ifdef MOD_SER_PREAMBLE_EN
      hold_q     <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod_bit_serializer.sv
// Bench for mod_bit_serializer: directed scenarios plus random byte traffic checked
// cycle by cycle against a queue of expected line bits built from each accepted byte.
module tb_mod_bit_serializer;

  localparam int MSB_FIRST = 1;
  localparam logic [7:0] PRE = 8'hAA;
`ifdef MOD_SER_PREAMBLE_EN
  localparam int PRE_BITS = 8;
`else
  localparam int PRE_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] baud_div = '0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, data_out, mod_en, bit_strobe, busy, frame_done;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // Each entry is one line cycle: {data bit, first cycle of bit, last cycle of byte}
  logic [2:0] exp_q[$];
  logic [7:0] cap;
  int n_strobe, n_mod;

  mod_bit_serializer #(.DATA_W(8), .DIV_W(8), .MSB_FIRST(MSB_FIRST), .PREAMBLE_BYTE(PRE)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .data_out(data_out), .mod_en(mod_en), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic [7:0] div, input logic is_data);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = (MSB_FIRST != 0) ? 7 - i : i;
      for (int k = 0; k <= int'(div); k++)
        exp_q.push_back({b[idx], k == 0, is_data && i == 7 && k == int'(div)});
    end
  endtask

  // One cycle: check outputs at the negedge, then drive inputs for the next edge
  task automatic step(input logic v, input logic [7:0] d, input logic [7:0] div, output logic acc);
    logic [2:0] e;
    logic present, exp_ready, from_idle;
    @(negedge clk);
    present   = exp_q.size() > 0;
    e         = present ? exp_q[0] : 3'b000;
    exp_ready = !present || (exp_q.size() == 1 && e[0]);
    check_eq("data_out", data_out, e[2]);
    check_eq("mod_en", mod_en, present);
    check_eq("bit_strobe", bit_strobe, e[1]);
    check_eq("frame_done", frame_done, e[0]);
    check_eq("busy", busy, present);
    check_eq("s_ready", s_ready, exp_ready);
    if (bit_strobe === 1'b1) begin
      cap = {cap[6:0], data_out};
      n_strobe++;
    end
    if (mod_en === 1'b1) n_mod++;
    s_valid  = v;
    s_data   = d;
    baud_div = div;
    acc       = v && exp_ready;
    from_idle = !present;
    if (present) void'(exp_q.pop_front());
    if (acc) begin
`ifdef MOD_SER_PREAMBLE_EN
      if (from_idle) push_frame(PRE, div, 1'b0);
`endif
      push_frame(d, div, 1'b1);
    end
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom_range(0, 3)), acc);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] div);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 3000) begin
      step(1'b1, d, div, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      idle_cycles(1);
      n++;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", 0, 1);
    idle_cycles(2);
  endtask

  task automatic clear_counts();
    cap = '0;
    n_strobe = 0;
    n_mod = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_mod_en", mod_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bit_strobe", bit_strobe, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_state", state_dbg, 0);
  endtask

  // Asynchronous reset raised between clock edges; outputs must clear before any edge
  task automatic do_reset();
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic acc;
    clear_counts();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Single byte, one bit per cycle
    clear_counts();
    send_byte(8'hA5, 8'd0);
    drain();
    check_eq("a5_bits", cap, 8'hA5);
    check_eq("a5_strobes", n_strobe, 8 + PRE_BITS);
    check_eq("a5_mod_cycles", n_mod, 8 + PRE_BITS);

    // Four cycles per bit
    clear_counts();
    send_byte(8'h81, 8'd3);
    drain();
    check_eq("81_bits", cap, 8'h81);
    check_eq("81_strobes", n_strobe, 8 + PRE_BITS);
    check_eq("81_mod_cycles", n_mod, 4 * (8 + PRE_BITS));

    // Back-to-back bytes with s_valid held
    clear_counts();
    send_byte(8'h0F, 8'd1);
    send_byte(8'hF0, 8'd1);
    drain();
    check_eq("b2b_bits", cap, 8'hF0);
    check_eq("b2b_strobes", n_strobe, 16 + PRE_BITS);
    check_eq("b2b_mod_cycles", n_mod, 2 * (16 + PRE_BITS));

    // Reset in the middle of a byte, then a fresh byte starts from bit 0
    send_byte(8'hFF, 8'd0);
    idle_cycles(3);
    do_reset();
    clear_counts();
    send_byte(8'h00, 8'd0);
    drain();
    check_eq("post_rst_bits", cap, 8'h00);
    check_eq("post_rst_strobes", n_strobe, 8 + PRE_BITS);
    check_eq("post_rst_mod_cycles", n_mod, 8 + PRE_BITS);

    // Random traffic: random bytes, dividers and gaps (gap 0 gives back-to-back)
    for (int i = 0; i < 60; i++) begin
      send_byte(8'($urandom), 8'($urandom_range(0, 3)));
      idle_cycles($urandom_range(0, 3));
      if (i == 30) begin
        idle_cycles($urandom_range(1, 6));
        do_reset();
      end
    end
    drain();
    step(1'b0, 8'h00, 8'h00, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_bit_serializer.md
Name: mod_bit_serializer

Overview:
Upstream feeder for the BPSK/QPSK modulator stage. Accepts bytes over a valid/ready handshake and shifts them out one bit at a time at a programmable bit rate. Drives the modulator's serial data input and modulate-enable input. modulate-enable stays high only while a bit is on the line.

Parameters:
DATA_W, 8, byte width in bits.
DIV_W, 8, width of the bit-period divider.
MSB_FIRST, 1, 1 = MSB transmitted first; 0 = LSB first.
PREAMBLE_BYTE, 8'hAA, preamble pattern; used only when MOD_SER_PREAMBLE_EN is defined.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
baud_div  in  DIV_W  bit period = baud_div+1 clk cycles; sampled when a byte is accepted.
s_data  in  DATA_W  byte to transmit.
s_valid  in  1  s_data valid.
s_ready  out  1  block can accept s_data this cycle.
data_out  out  1  serial bit; connects to the modulator data_in.
mod_en  out  1  bit on line; connects to the modulator modulate_enable.
bit_strobe  out  1  one-cycle pulse on the first cycle of each bit period.
busy  out  1  state != IDLE.
frame_done  out  1  one-cycle pulse on the last cycle of a byte's last bit.

Behaviour:
- Reset (async): all outputs 0, except s_ready = 0 while rst is high. FSM goes to IDLE. Counters, shift register and the latched divider clear. Any in-flight byte is discarded. s_ready = 1 on the first cycle after rst deasserts.
- All outputs are registered.
- FSM states: IDLE, SHIFT, plus PREAMBLE when the optional feature is enabled.
- IDLE: s_ready = 1, mod_en = 0, data_out = 0.
- Accept: on a clk edge with s_valid && s_ready, the block:
  - loads shift register ← s_data, div_latch ← baud_div, div_cnt ← baud_div, bit_cnt ← 0;
  - enters SHIFT.
  - From that edge: data_out = first bit, mod_en = 1, bit_strobe = 1 for one cycle. Latency from accept edge to first bit: 0 cycles (visible right after the edge).
- SHIFT: div_cnt decrements every cycle.
  - When div_cnt == 0 and bit_cnt < DATA_W-1: shift to the next bit, bit_cnt++, div_cnt ← div_latch, pulse bit_strobe.
  - baud_div = 0 gives one bit per cycle.
- Last bit (bit_cnt == DATA_W-1, div_cnt == 0): frame_done = 1 and s_ready = 1 in that cycle.
  - If s_valid is high: the new byte is accepted at that edge and the first bit follows with no gap. mod_en never drops between bytes.
  - Otherwise: go to IDLE, with mod_en = 0 and data_out = 0 after the edge.
- Everywhere except IDLE and the last cycle of the last bit, s_ready = 0.
- Upstream must hold s_data/s_valid stable while s_valid && !s_ready. The block ignores s_data when s_valid is low.
- baud_div changes mid-byte have no effect until the next accept.
- Bit order: MSB_FIRST = 1 sends s_data[DATA_W-1] first; otherwise s_data[0] first.
- A byte occupies exactly DATA_W*(baud_div+1) cycles of mod_en.

Optional Feature:
MOD_SER_PREAMBLE_EN.
- Defined: an accept from IDLE (not a back-to-back accept) stores the byte in a hold register and enters PREAMBLE.
  - PREAMBLE_BYTE is transmitted with identical timing and bit order; s_ready = 0 throughout; frame_done is not pulsed for it.
  - The held byte then follows gap-free in SHIFT.
  - Back-to-back bytes get no preamble.
- Undefined: the PREAMBLE state, hold register and PREAMBLE_BYTE logic are absent; behaviour is as described above.

Test Plan:
- Reset: rst=1 mid-run → data_out, mod_en, busy, bit_strobe, frame_done and s_ready all 0 without waiting for a clk edge; after release, s_ready=1, mod_en=0.
- Single byte, baud_div=0, MSB_FIRST=1, s_data=8'hA5 → data_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; mod_en high exactly 8 cycles; bit_strobe high all 8; frame_done on cycle 8; then IDLE.
- baud_div=3, s_data=8'h81 → each bit held 4 cycles; mod_en high 32 cycles; bit_strobe pulses every 4th cycle (8 pulses); frame_done on cycle 32.
- Back-to-back: s_valid held with 8'h0F then 8'hF0, baud_div=1 → 32 contiguous mod_en cycles with pattern 0000 1111 1111 0000 (bit periods); s_ready high only on cycle 16 and before the first accept.
- Reset mid-byte after 3 bits of 8'hFF → outputs clear immediately; next accepted 8'h00 starts at bit 0 and emits 8 zero bits with mod_en high.
- With MOD_SER_PREAMBLE_EN, baud_div=0, s_data=8'h3C → 16 bits 10101010 00111100; s_ready low for all 16 except the last cycle; frame_done once, on cycle 16.
